// File: rtl/trig_capture.sv
`default_nettype none
// ============================================================================
// Module   : trig_capture
// Purpose  : Triggered acquisition buffer. Records the 14-bit ADC stream into
//            a circular RAM once armed, locks onto the first rising edge of
//            trg after the pre-trigger window has filled, captures the
//            post-trigger samples and then plays the frame back oldest-first.
//            The trigger sample always lands at read index PRE.
// Revision : 1.0  initial release
// ============================================================================
module trig_capture #(
    parameter int AW  = 10,
    parameter int PRE = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic [13:0] ain,
    input  logic        trg,
    output logic        busy,
    output logic        done,
    input  logic        rd_req,
    output logic [13:0] rd_data,
    output logic        rd_valid
);

    localparam int DEPTH = 1 << AW;

    // State encoding
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_PRE_FILL = 3'd1;
    localparam logic [2:0] c_WAIT_TRG = 3'd2;
    localparam logic [2:0] c_POST     = 3'd3;
    localparam logic [2:0] c_READ     = 3'd4;

    // Pointer / counter constants, all AW-bit so arithmetic wraps naturally
    localparam logic [AW-1:0] c_ONE      = AW'(1);
    localparam logic [AW-1:0] c_PRE_LAST = AW'(PRE - 1);
    localparam logic [AW-1:0] c_PRE_OFS  = AW'(PRE);
    localparam logic [AW-1:0] c_POST_LEN = AW'(DEPTH - PRE - 1);
    // Read counter needs one extra bit to hold a full frame count
    localparam logic [AW:0]   c_RCNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_RCNT_ONE  = (AW+1)'(1);
    // With PRE = DEPTH-1 the trigger sample is also the last sample
    localparam logic          c_NO_POST  = ((DEPTH - PRE - 1) == 0);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;

    logic          r_trg_d;
    logic          w_trg_edge;

    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_tp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_rcnt;

    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_trig_hit;
    logic          w_post_last;
    logic          w_frame_end;
    logic [AW-1:0] w_rp_start;

    logic [13:0]   r_mem [DEPTH];
    logic [13:0]   r_rd_data;
    logic          r_rd_valid;

    // Rising-edge detect; trg_d resets high so a level held through reset
    // cannot masquerade as an edge.
    assign w_trg_edge = trg & ~r_trg_d;

    // Trigger accepted this cycle (arm always takes priority)
    assign w_trig_hit  = (r_state == c_WAIT_TRG) & w_trg_edge & ~arm;
    // Last post-trigger write this cycle
    assign w_post_last = (r_state == c_POST) & (r_cnt == c_ONE) & ~arm;
    // Frame complete: either the normal end of POST or a trigger with no POST
    assign w_frame_end = w_post_last | (w_trig_hit & c_NO_POST);
    // Oldest sample sits PRE slots before the trigger sample
    assign w_rp_start  = (w_trig_hit ? r_wp : r_tp) - c_PRE_OFS;

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

    // Trigger delay register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trg_d <= 1'b1;
        end else begin
            r_trg_d <= trg;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; arm restarts from any state
    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = c_PRE_FILL;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_state_nxt = c_IDLE;
                end
                c_PRE_FILL: begin
                    if (r_cnt == c_PRE_LAST) begin
                        w_state_nxt = c_WAIT_TRG;
                    end
                end
                c_WAIT_TRG: begin
                    if (w_trg_edge) begin
                        w_state_nxt = c_NO_POST ? c_READ : c_POST;
                    end
                end
                c_POST: begin
                    if (r_cnt == c_ONE) begin
                        w_state_nxt = c_READ;
                    end
                end
                c_READ: begin
                    if (rd_req && (r_rcnt == c_RCNT_ONE)) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: status flags and RAM port enables
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        case (r_state)
            c_PRE_FILL, c_WAIT_TRG, c_POST: begin
                busy    = 1'b1;
                w_wr_en = ~arm;
            end
            c_READ: begin
                done    = 1'b1;
                w_rd_en = rd_req & ~arm;
            end
            default: begin
                busy    = 1'b0;
            end
        endcase
    end

    // Write pointer, capture counter, trigger pointer and readout bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp   <= '0;
            r_cnt  <= '0;
            r_tp   <= '0;
            r_rp   <= '0;
            r_rcnt <= '0;
        end else if (arm) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_wp <= r_wp + c_ONE;
            end

            if (r_state == c_PRE_FILL) begin
                r_cnt <= r_cnt + c_ONE;
            end else if (w_trig_hit) begin
                r_tp  <= r_wp;
                r_cnt <= c_POST_LEN;
            end else if (r_state == c_POST) begin
                r_cnt <= r_cnt - c_ONE;
            end

            if (w_frame_end) begin
                r_rp   <= w_rp_start;
                r_rcnt <= c_RCNT_FULL;
            end else if (w_rd_en) begin
                r_rp   <= r_rp + c_ONE;
                r_rcnt <= r_rcnt - c_RCNT_ONE;
            end
        end
    end

    // Sample RAM write port (contents are not reset)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wp] <= ain;
        end
    end

    // Registered readout: data and its qualifying strobe one cycle after rd_req
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_data <= r_mem[r_rp];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trig_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_capture
// Purpose  : Self-checking bench for trig_capture (AW=4, PRE=4, DEPTH=16).
//            Expected frames come from the recorded input stream and the
//            first qualifying trigger edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_trig_capture;

    localparam int AW    = 4;
    localparam int PRE   = 4;
    localparam int DEPTH = 16;
    localparam int MAXW  = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic [13:0] ain;
    logic        trg;
    logic        busy;
    logic        done;
    logic        rd_req;
    logic [13:0] rd_data;
    logic        rd_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus plan for one acquisition: sample and trg level per write cycle
    logic [13:0] pat_ain [MAXW];
    bit          pat_trg [MAXW];
    bit          trg_pre;

    // Observations gathered by the stimulus helpers
    int          done_at;
    bit          busy_ok;
    bit          valid_seen;
    logic [13:0] got [32];
    int          nvalid;
    bit          strobe_ok;
    logic        done_last;

    trig_capture #(.AW(AW), .PRE(PRE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .ain      (ain),
        .trg      (trg),
        .busy     (busy),
        .done     (done),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // First write index (>= PRE) where trg goes low -> high.
    function automatic int model_trig();
        bit prev;
        for (int k = PRE; k < MAXW; k++) begin
            prev = (k == 0) ? trg_pre : pat_trg[k-1];
            if (pat_trg[k] && !prev) return k;
        end
        return -1;
    endfunction

    // Index of the last write of the frame, or -1 if not reached within limit.
    function automatic int model_done(input int limit);
        int k;
        k = model_trig();
        if (k < 0) return -1;
        if (k + DEPTH - PRE - 1 >= limit) return -1;
        return k + DEPTH - PRE - 1;
    endfunction

    function automatic int frame_base();
        int k;
        k = model_trig() - PRE;
        return (k < 0) ? 0 : k;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic clear_pat();
        for (int w = 0; w < MAXW; w++) begin
            pat_ain[w] = 14'(w);
            pat_trg[w] = 1'b0;
        end
        trg_pre = 1'b0;
    endtask

    task automatic set_trg(input int from, input int to, input bit val);
        for (int w = from; w <= to && w < MAXW; w++) pat_trg[w] = val;
    endtask

    // Arm, then stream writes until done rises or limit writes elapse.
    task automatic run_acq(input int limit);
        done_at    = -1;
        busy_ok    = 1'b1;
        valid_seen = 1'b0;
        trg = trg_pre;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int w = 0; w < limit; w++) begin
            ain = pat_ain[w];
            trg = pat_trg[w];
            if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
            if (rd_valid === 1'b1) valid_seen = 1'b1;
            step();
            if (rd_valid === 1'b1) valid_seen = 1'b1;
            if (done === 1'b1) begin
                done_at = w;
                break;
            end
        end
    endtask

    // Issue nreq read requests (optionally with random gaps) and collect data.
    task automatic read_frame(input int nreq, input bit gaps);
        int issued;
        int cyc;
        bit req;
        issued    = 0;
        cyc       = 0;
        nvalid    = 0;
        strobe_ok = 1'b1;
        done_last = 1'b1;
        while (issued < nreq && cyc < 400) begin
            req = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            rd_req = req;
            step();
            cyc++;
            if (req) issued++;
            if (rd_valid !== (req && issued <= DEPTH)) strobe_ok = 1'b0;
            if (rd_valid === 1'b1) begin
                if (nvalid < 32) got[nvalid] = rd_data;
                nvalid++;
                if (nvalid == DEPTH) done_last = done;
            end
        end
        rd_req = 1'b0;
        step();
        if (rd_valid !== 1'b0) strobe_ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; ain = '0; trg = 1'b1; rd_req = 1'b0;
        repeat (3) step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_cmp++; if (rd_data !== 14'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
        #2 rst_n = 1'b1;
        step();
        trg = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int b, e;
        clear_pat();
        set_trg(9, MAXW-1, 1'b1);
        e = model_done(60);
        run_acq(60);
        n_cmp++; if (done_at !== e) begin n_bad++; $display("FAIL basic_done_at: got %0d expected %0d", done_at, e); end
        n_cmp++; if (busy_ok !== 1'b1) begin n_bad++; $display("FAIL basic_busy_during: got %b expected 1", busy_ok); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
        read_frame(DEPTH, 1'b0);
        b = frame_base();
        n_cmp++; if (nvalid !== DEPTH) begin n_bad++; $display("FAIL basic_nvalid: got %0d expected %0d", nvalid, DEPTH); end
        n_cmp++; if (strobe_ok !== 1'b1) begin n_bad++; $display("FAIL basic_strobe: got %b expected 1", strobe_ok); end
        n_cmp++; if (done_last !== 1'b0) begin n_bad++; $display("FAIL basic_done_after_last: got %b expected 0", done_last); end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (got[i] !== pat_ain[b+i]) begin
                n_bad++; $display("FAIL basic_frame[%0d]: got %h expected %h", i, got[i], pat_ain[b+i]);
            end
        end
    endtask

    task automatic test_early();
        int b, e;
        clear_pat();
        set_trg(1, 1, 1'b1);
        set_trg(6, MAXW-1, 1'b1);
        e = model_done(60);
        run_acq(60);
        n_cmp++; if (done_at !== e) begin n_bad++; $display("FAIL early_done_at: got %0d expected %0d", done_at, e); end
        read_frame(DEPTH, 1'b0);
        b = frame_base();
        n_cmp++; if (nvalid !== DEPTH) begin n_bad++; $display("FAIL early_nvalid: got %0d expected %0d", nvalid, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (got[i] !== pat_ain[b+i]) begin
                n_bad++; $display("FAIL early_frame[%0d]: got %h expected %h", i, got[i], pat_ain[b+i]);
            end
        end
    endtask

    task automatic test_held();
        int b, e;
        clear_pat();
        trg_pre = 1'b1;
        set_trg(0, 7, 1'b1);
        set_trg(10, MAXW-1, 1'b1);
        e = model_done(60);
        run_acq(60);
        n_cmp++; if (done_at !== e) begin n_bad++; $display("FAIL held_done_at: got %0d expected %0d", done_at, e); end
        read_frame(DEPTH, 1'b0);
        b = frame_base();
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (got[i] !== pat_ain[b+i]) begin
                n_bad++; $display("FAIL held_frame[%0d]: got %h expected %h", i, got[i], pat_ain[b+i]);
            end
        end
    endtask

    task automatic test_wrap();
        int b, e;
        clear_pat();
        set_trg(39, MAXW-1, 1'b1);
        e = model_done(100);
        run_acq(100);
        n_cmp++; if (done_at !== e) begin n_bad++; $display("FAIL wrap_done_at: got %0d expected %0d", done_at, e); end
        read_frame(DEPTH, 1'b0);
        b = frame_base();
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (got[i] !== pat_ain[b+i]) begin
                n_bad++; $display("FAIL wrap_frame[%0d]: got %h expected %h", i, got[i], pat_ain[b+i]);
            end
        end
    endtask

    task automatic test_gating();
        bit idle_valid;
        int b, e;
        idle_valid = 1'b0;
        rd_req = 1'b1;
        repeat (3) begin
            step();
            if (rd_valid !== 1'b0) idle_valid = 1'b1;
        end
        n_cmp++; if (idle_valid !== 1'b0) begin n_bad++; $display("FAIL gate_idle_valid: got %b expected 0", idle_valid); end
        clear_pat();
        set_trg(12, MAXW-1, 1'b1);
        e = model_done(60);
        run_acq(60);
        n_cmp++; if (valid_seen !== 1'b0) begin n_bad++; $display("FAIL gate_capture_valid: got %b expected 0", valid_seen); end
        n_cmp++; if (done_at !== e) begin n_bad++; $display("FAIL gate_done_at: got %0d expected %0d", done_at, e); end
        read_frame(DEPTH + 1, 1'b0);
        b = frame_base();
        n_cmp++; if (nvalid !== DEPTH) begin n_bad++; $display("FAIL gate_nvalid_17req: got %0d expected %0d", nvalid, DEPTH); end
        n_cmp++; if (strobe_ok !== 1'b1) begin n_bad++; $display("FAIL gate_strobe: got %b expected 1", strobe_ok); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL gate_done_end: got %b expected 0", done); end
        n_cmp++; if (got[PRE] !== pat_ain[b+PRE]) begin n_bad++; $display("FAIL gate_trig_sample: got %h expected %h", got[PRE], pat_ain[b+PRE]); end
    endtask

    task automatic test_abort_reset();
        int b, e;
        // Trigger early, stop streaming mid-POST, then re-arm
        clear_pat();
        set_trg(5, MAXW-1, 1'b1);
        e = model_done(8);
        run_acq(8);
        n_cmp++; if (done_at !== e) begin n_bad++; $display("FAIL abort_partial_done_at: got %0d expected %0d", done_at, e); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_post_busy: got %b expected 1", busy); end
        clear_pat();
        for (int w = 0; w < MAXW; w++) pat_ain[w] = 14'(w + 1000);
        set_trg(20, MAXW-1, 1'b1);
        e = model_done(60);
        run_acq(60);
        n_cmp++; if (done_at !== e) begin n_bad++; $display("FAIL abort_rearm_done_at: got %0d expected %0d", done_at, e); end
        read_frame(DEPTH, 1'b0);
        b = frame_base();
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (got[i] !== pat_ain[b+i]) begin
                n_bad++; $display("FAIL abort_frame[%0d]: got %h expected %h", i, got[i], pat_ain[b+i]);
            end
        end
        // Asynchronous reset in the middle of a readout
        clear_pat();
        set_trg(8, MAXW-1, 1'b1);
        run_acq(60);
        rd_req = 1'b1;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rd_valid: got %b expected 0", rd_valid); end
        rd_req = 1'b0;
        #2 rst_n = 1'b1;
        step();
        trg = 1'b0;
        step();
        clear_pat();
        for (int w = 0; w < MAXW; w++) pat_ain[w] = 14'(3 * w + 7);
        set_trg(15, MAXW-1, 1'b1);
        e = model_done(60);
        run_acq(60);
        n_cmp++; if (done_at !== e) begin n_bad++; $display("FAIL rst_after_done_at: got %0d expected %0d", done_at, e); end
        read_frame(DEPTH, 1'b0);
        b = frame_base();
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (got[i] !== pat_ain[b+i]) begin
                n_bad++; $display("FAIL rst_after_frame[%0d]: got %h expected %h", i, got[i], pat_ain[b+i]);
            end
        end
    endtask

    task automatic test_random();
        int b, e;
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < MAXW; w++) begin
                pat_ain[w] = 14'($urandom);
                pat_trg[w] = ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0;
            end
            trg_pre = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            e = model_done(150);
            run_acq(150);
            n_cmp++; if (done_at !== e) begin n_bad++; $display("FAIL rand%0d_done_at: got %0d expected %0d", it, done_at, e); end
            if (e >= 0 && done_at == e) begin
                read_frame(DEPTH, 1'b1);
                b = frame_base();
                n_cmp++; if (strobe_ok !== 1'b1) begin n_bad++; $display("FAIL rand%0d_strobe: got %b expected 1", it, strobe_ok); end
                n_cmp++; if (nvalid !== DEPTH) begin n_bad++; $display("FAIL rand%0d_nvalid: got %0d expected %0d", it, nvalid, DEPTH); end
                for (int i = 0; i < DEPTH; i++) begin
                    n_cmp++;
                    if (got[i] !== pat_ain[b+i]) begin
                        n_bad++; $display("FAIL rand%0d_frame[%0d]: got %h expected %h", it, i, got[i], pat_ain[b+i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early();
        test_held();
        test_wrap();
        test_gating();
        test_abort_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trig_capture.md
# trig_capture

Acquisition buffer that sits directly downstream of the Schmitt-trigger stage. It continuously records the 14-bit ADC stream into a circular RAM once armed. It takes the first rising edge of `trg` after the pre-trigger window has filled, captures the post-trigger samples, and then offers the frame for sequential readout, oldest sample first. The trigger sample always sits at read index `PRE`.

## Interface
- `AW`, 10: RAM address width; DEPTH = 2^AW samples per frame.
- `PRE`, 256: pre-trigger samples per frame; legal range 1 .. DEPTH-2.
- `clk`  in  1  sample clock, same domain as the ADC and the trigger stage.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arm`  in  1  single-cycle pulse; starts or restarts an acquisition.
- `ain`  in  14  raw ADC sample, offset binary, stored unmodified.
- `trg`  in  1  trigger level from the upstream stage; only its rising edge is used.
- `busy`  out  1  high in PRE_FILL, WAIT_TRG and POST.
- `done`  out  1  high in READ; a frame is available.
- `rd_req`  in  1  pop one sample; honoured only in READ.
- `rd_data`  out  14  read sample.
- `rd_valid`  out  1  single-cycle strobe qualifying `rd_data`.

## Operation
- Edge detect: `trg_d` is `trg` registered. `trg_edge = trg & ~trg_d`. `trg_d` resets to 1, so a `trg` held high through reset does not fire.
- State IDLE: no writes. `arm` -> PRE_FILL, with `wp`=0 and `cnt`=0.
- State PRE_FILL: each cycle writes `ain` to RAM[`wp`], then `wp`++ mod DEPTH and `cnt`++. `trg_edge` is ignored. After the write with `cnt`==PRE-1 -> WAIT_TRG.
- State WAIT_TRG: writes every cycle, and `wp` wraps freely. On `trg_edge`, the sample written that same cycle is the trigger sample. Store `tp`=`wp`, load `cnt`=DEPTH-PRE-1, then -> POST. A `trg` already high on entry needs a fresh low->high transition.
- State POST: writes every cycle and decrements `cnt`. The write with `cnt`==1 is the last one; in that cycle set `rp` = (`tp` - PRE) mod DEPTH and `rcnt`=DEPTH, then -> READ. If DEPTH-PRE-1 = 0, go straight to READ from the trigger cycle.
- Frame content: exactly PRE samples before the trigger sample, the trigger sample, and DEPTH-PRE-1 samples after it. All index arithmetic is AW-bit unsigned with natural wrap.
- State READ: no writes. `rd_req` reads RAM[`rp`], then `rp`++ mod DEPTH and `rcnt`--. `rd_req` in the cycle `rcnt`==1 is the last read; the state goes -> IDLE, and `rd_valid` for that read still fires one cycle later. `rd_req` in any other state is ignored.
- `arm` in any state other than IDLE aborts the current activity and restarts at PRE_FILL. The old frame is lost. An `arm` in READ wins over a simultaneous `rd_req`.
- No alignment compensation: the trigger stage's pipeline delay relative to `ain` is part of the frame position and is calibrated in software.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0, `trg_d`=1, all counters and pointers 0. RAM contents are undefined.
- The RAM is single-port synchronous: one write per cycle in the capture states, and read data is registered.
- `arm` at cycle N: `busy`=1 from N+1, and the first write happens at N+1 (`ain` at N+1).
- Capture length from the trigger sample is DEPTH-PRE cycles. `done` rises the cycle after the last write, and `busy` falls in that same cycle.
- Read latency is 1: `rd_req` at cycle N gives `rd_data` and `rd_valid` at N+1. Back-to-back `rd_req` gives one sample per cycle.
- After the last read, `done` falls at N+1. The final `rd_valid` appears at that same N+1.
- `rst_n` asserted mid-operation returns the block to IDLE immediately (asynchronous). `rd_valid` drops with it and no partial frame is kept.

## Test plan
All scenarios use AW=4 and PRE=4, so DEPTH=16. `ain` is a counter starting at 0x0000 on the first write cycle.
- Basic capture: arm, then a trg edge on write #10 (`ain`=9). Expect `done` after 11 more writes. 16 reads return 5..20 in order, `rd_valid` each cycle, and read index 4 = 9.
- Early trigger: `trg` pulses on write #2 and again on write #7 (`ain`=6). Expect the first edge ignored; the frame is 2..17 with 6 at index 4.
- Held trigger: `trg`=1 from before arm until write #8, low 2 cycles, rising at write #11 (`ain`=10). Expect no capture until write #11; frame 6..21.
- Wrap-around: trigger after 40 writes (`ain`=39, `tp`=7). Expect the frame to read 35..50 contiguously across the RAM wrap, starting at `rp`=3.
- Readout gating: `rd_req` in IDLE, PRE_FILL and POST produces no `rd_valid`. During READ, a 17th `rd_req` produces nothing, and `done`=0 after the 16th.
- Abort and reset: `arm` during POST restarts, and a new frame with a new trigger is correct. `rst_n`=0 during READ mid-frame forces `done`=0, `busy`=0 and `rd_valid`=0 within the same cycle; a later arm works normally.
